// File: rtl/uart_cmd_responder.sv
// Host register-access command parser: turns 'W' addr data / 'R' addr byte
// streams into local register bus strobes and one response byte per command.
module uart_cmd_responder #(
  parameter int TIMEOUT_CLKS = 34720,
  parameter int NUM_REGS     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_done,
  output logic       o_reg_we,
  output logic       o_reg_re,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy,
  output logic [7:0] o_err_cnt
);

  localparam int            CW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] T_LAST   = CW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]    ADDR_LIM = 9'(NUM_REGS);
  localparam logic [7:0]    CMD_W    = 8'h57;
  localparam logic [7:0]    CMD_R    = 8'h52;
  localparam logic [7:0]    ACK      = 8'h06;
  localparam logic [7:0]    NAK      = 8'h15;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, WR, REG_RD, REG_CAP, SEND, WAIT_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            cmd_wr, cmd_wr_nxt;
  logic [7:0]      resp, resp_nxt;
  logic            err_inc, load_addr, load_data;
  logic [CW-1:0]   tcnt;

  always_comb begin
    state_nxt  = state;
    cmd_wr_nxt = cmd_wr;
    resp_nxt   = resp;
    err_inc    = 1'b0;
    load_addr  = 1'b0;
    load_data  = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_dv) begin
          if (i_rx_byte == CMD_W) begin
            cmd_wr_nxt = 1'b1;
            state_nxt  = GET_ADDR;
          end else if (i_rx_byte == CMD_R) begin
            cmd_wr_nxt = 1'b0;
            state_nxt  = GET_ADDR;
          end else begin
            resp_nxt  = NAK;
            err_inc   = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (i_rx_dv) begin
          load_addr = 1'b1;
          if ({1'b0, i_rx_byte} >= ADDR_LIM) begin
            resp_nxt  = NAK;
            err_inc   = 1'b1;
            state_nxt = SEND;
          end else begin
            state_nxt = cmd_wr ? GET_DATA : REG_RD;
          end
        end else if (tcnt == T_LAST) begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GET_DATA: begin
        if (i_rx_dv) begin
          load_data = 1'b1;
          state_nxt = WR;
        end else if (tcnt == T_LAST) begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      // Bytes arriving while a command is being serviced are dropped and counted.
      WR: begin
        resp_nxt  = ACK;
        err_inc   = i_rx_dv;
        state_nxt = SEND;
      end
      REG_RD: begin
        err_inc   = i_rx_dv;
        state_nxt = REG_CAP;
      end
      REG_CAP: begin
        resp_nxt  = i_reg_rdata;
        err_inc   = i_rx_dv;
        state_nxt = SEND;
      end
      SEND: begin
        err_inc   = i_rx_dv;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        err_inc = i_rx_dv;
        if (i_tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cmd_wr      <= 1'b0;
      resp        <= 8'h00;
      o_reg_addr  <= 8'h00;
      o_reg_wdata <= 8'h00;
      o_err_cnt   <= 8'h00;
      tcnt        <= '0;
    end else begin
      state  <= state_nxt;
      cmd_wr <= cmd_wr_nxt;
      resp   <= resp_nxt;
      if (load_addr) o_reg_addr  <= i_rx_byte;
      if (load_data) o_reg_wdata <= i_rx_byte;
      if (err_inc && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
      // Counts idle cycles between bytes; any accepted byte restarts the window.
      if (((state == GET_ADDR) || (state == GET_DATA)) && !i_rx_dv)
        tcnt <= tcnt + CW'(1);
      else
        tcnt <= '0;
    end
  end

  assign o_tx_dv   = (state == SEND);
  assign o_reg_we  = (state == WR);
  assign o_reg_re  = (state == REG_RD);
  assign o_busy    = (state != IDLE);
  assign o_tx_byte = resp;

endmodule
